// File: rtl/csel_pkg.sv
// ----------------------------------------------------------------------------
// csel_pkg
// Shared definitions for the pipelined carry-select adder/subtractor.
//   nblk()      : number of carry-select blocks for a given width/block size
//   FLAG_*      : bit positions inside the {zero, ovf, cout} flag vector
// The per-block {sum0, sum1, c0, c1} record depends on the block width, so
// its packed struct is declared in csel_adder_pipe from that module's BLK.
// ----------------------------------------------------------------------------
package csel_pkg;

  // Flag vector layout: {zero, ovf, cout}, cout in the LSB.
  localparam int unsigned FLAG_W    = 32'd3;
  localparam int unsigned FLAG_COUT = 32'd0;
  localparam int unsigned FLAG_OVF  = 32'd1;
  localparam int unsigned FLAG_ZERO = 32'd2;

  // Number of BLK-wide blocks covering WIDTH bits; 0 flags an illegal BLK.
  function automatic int nblk(input int width, input int blk);
    if (blk <= 32'sd0) begin
      return 32'sd0;
    end else begin
      return width / blk;
    end
  endfunction

endpackage

// File: rtl/csel_adder_pipe_block.sv
// ----------------------------------------------------------------------------
// csel_block
// Combinational ripple block of a carry-select adder. Produces the block sum
// and carry-out for both possible incoming carries so the real carry only
// has to steer a mux later.
// Ports:
//   a, b   : BLK-bit block operands (b already inverted for subtract)
//   sum0   : a + b            (carry-in 0)
//   sum1   : a + b + 1        (carry-in 1)
//   c0, c1 : carry-out of the corresponding sum
// ----------------------------------------------------------------------------
module csel_block
  import csel_pkg::*;
#(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic [BLK-1:0] sum1,
  output logic           c0,
  output logic           c1
);

  logic [BLK:0] full0_s;
  logic [BLK:0] full1_s;

  // One extra bit on each operand captures the block carry-out.
  assign full0_s = {1'b0, a} + {1'b0, b};
  assign full1_s = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

  assign sum0 = full0_s[BLK-1:0];
  assign sum1 = full1_s[BLK-1:0];
  assign c0   = full0_s[BLK];
  assign c1   = full1_s[BLK];

endmodule

// File: rtl/csel_adder_pipe.sv
// ----------------------------------------------------------------------------
// csel_adder_pipe
// Two-stage pipelined carry-select adder/subtractor with valid/ready
// handshaking on both sides and full backpressure.
//   Stage 1: block 0 is added with the real carry-in, every other block is
//            added speculatively for carry-in 0 and 1 (csel_block).
//   Stage 2: the carry-select chain picks the real block sums, then the
//            result and its flags are registered as the outputs.
// Result = in_a + (in_sub ? ~in_b : in_b) + in_cin  (mod 2^WIDTH).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand beat handshake (in_ready is combinational)
//   in_a, in_b           : WIDTH-bit operands
//   in_cin, in_sub       : carry-in, subtract mode
//   out_valid / out_ready: result beat handshake
//   out_sum              : WIDTH-bit result
//   out_cout             : raw carry-out of the MSB (not inverted in subtract)
//   out_ovf              : two's-complement signed overflow
//   out_zero             : out_sum == 0
// ----------------------------------------------------------------------------
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int          NBLK = nblk(int'(WIDTH), int'(BLK));
  localparam int unsigned MSB  = WIDTH - 32'd1;

  generate
    if ((BLK == 32'd0) || ((WIDTH % BLK) != 32'd0) || (NBLK < 32'sd1)) begin : g_bad_params
      $error("csel_adder_pipe: WIDTH (%0d) must be a non-zero multiple of BLK (%0d)", WIDTH, BLK);
    end
  endgenerate

  // Speculative result of one block: sums and carries for carry-in 0 and 1.
  typedef struct packed {
    logic [BLK-1:0] sum0;
    logic [BLK-1:0] sum1;
    logic           c0;
    logic           c1;
  } blk_pair_t;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic adv1_s;
  logic adv2_s;
  logic accept_s;
  logic v1_r;
  logic out_valid_r;

  assign adv2_s   = !out_valid_r || out_ready;
  assign adv1_s   = !v1_r || adv2_s;
  assign accept_s = in_valid && adv1_s;
  assign in_ready = adv1_s;

  // --------------------------------------------------------------------------
  // Stage 1 combinational: operand conditioning and per-block additions
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]           b_eff_s;
  blk_pair_t [NBLK-1:0]       pair_s;

  assign b_eff_s = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_first
      // Block 0 knows its real carry-in; both halves of its pair hold the
      // same value so the select chain treats all blocks uniformly.
      logic [BLK:0] full_s;
      assign full_s = {1'b0, in_a[BLK-1:0]} + {1'b0, b_eff_s[BLK-1:0]}
                    + {{BLK{1'b0}}, in_cin};
      assign pair_s[k] = {full_s[BLK-1:0], full_s[BLK-1:0], full_s[BLK], full_s[BLK]};
    end else begin : g_sel
      logic [BLK-1:0] sum0_s;
      logic [BLK-1:0] sum1_s;
      logic           c0_s;
      logic           c1_s;
      csel_block #(
        .BLK (BLK)
      ) u_blk (
        .a    (in_a[k*BLK +: BLK]),
        .b    (b_eff_s[k*BLK +: BLK]),
        .sum0 (sum0_s),
        .sum1 (sum1_s),
        .c0   (c0_s),
        .c1   (c1_s)
      );
      assign pair_s[k] = {sum0_s, sum1_s, c0_s, c1_s};
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  blk_pair_t [NBLK-1:0] pair_r;
  logic                 a_msb_r;
  logic                 b_msb_r;

  // Stage 1 register: captures speculative block results when stage 1 advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      pair_r  <= '0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else if (adv1_s) begin
      v1_r    <= accept_s;
      pair_r  <= pair_s;
      a_msb_r <= in_a[MSB];
      b_msb_r <= b_eff_s[MSB];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 combinational: carry-select chain and flags
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  sel_sum_s;
  logic              sel_carry_s;
  logic [FLAG_W-1:0] sel_flags_s;

  // Carry-select chain: each block's sum and carry are chosen by the carry
  // leaving the previous block. Block 0 holds identical halves, so the
  // constant starting carry does not matter.
  always_comb begin
    sel_sum_s   = {WIDTH{1'b0}};
    sel_carry_s = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      if (sel_carry_s) begin
        sel_sum_s[k*BLK +: BLK] = pair_r[k].sum1;
        sel_carry_s             = pair_r[k].c1;
      end else begin
        sel_sum_s[k*BLK +: BLK] = pair_r[k].sum0;
        sel_carry_s             = pair_r[k].c0;
      end
    end
  end

  // Status flags derived from the selected sum and the stored operand MSBs.
  always_comb begin
    sel_flags_s            = {FLAG_W{1'b0}};
    sel_flags_s[FLAG_COUT] = sel_carry_s;
    sel_flags_s[FLAG_OVF]  = (a_msb_r == b_msb_r) && (sel_sum_s[MSB] != a_msb_r);
    sel_flags_s[FLAG_ZERO] = (sel_sum_s == {WIDTH{1'b0}});
  end

  // --------------------------------------------------------------------------
  // Stage 2 registers (outputs)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  sum_r;
  logic [FLAG_W-1:0] flags_r;

  // Output register: loads the selected result whenever the output can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      flags_r     <= {FLAG_W{1'b0}};
    end else if (adv2_s) begin
      out_valid_r <= v1_r;
      sum_r       <= sel_sum_s;
      flags_r     <= sel_flags_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = sum_r;
  assign out_cout  = flags_r[FLAG_COUT];
  assign out_ovf   = flags_r[FLAG_OVF];
  assign out_zero  = flags_r[FLAG_ZERO];

endmodule

// File: tb/tb_csel_adder_pipe.sv
// ----------------------------------------------------------------------------
// tb_csel_adder_pipe
// Two instances: WIDTH=16/BLK=4 and WIDTH=8/BLK=8. Directed cases run on the
// 16-bit instance, random traffic runs on both. A reference model computes
// results with plain integer arithmetic; a queue per instance keeps the
// expected beats in acceptance order.
// Packed observation/expectation format: {zero, ovf, cout, sum[31:0]}.
// ----------------------------------------------------------------------------
module tb_csel_adder_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        iv16, ir16, ci16, sb16, ov16, or16, co16, of16, z16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ci8, sb8, ov8, or8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;

  csel_adder_pipe #(.WIDTH(16), .BLK(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_cin(ci16), .in_sub(sb16),
    .out_valid(ov16), .out_ready(or16), .out_sum(s16),
    .out_cout(co16), .out_ovf(of16), .out_zero(z16)
  );

  csel_adder_pipe #(.WIDTH(8), .BLK(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_cin(ci8), .in_sub(sb8),
    .out_valid(ov8), .out_ready(or8), .out_sum(s8),
    .out_cout(co8), .out_ovf(of8), .out_zero(z8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rcv16 = 0;
  int rcv8  = 0;
  logic [34:0] q16[$];
  logic [34:0] q8[$];

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a + (sub ? ~b : b) + cin at width w, flags from integer ranges.
  function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic sub);
    longint mask, half, ua, ub, full, sa, sbv, ss;
    logic [31:0] sum;
    logic cout, ovf;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = (sub ? longint'(~b) : longint'(b)) & mask;
    full = ua + ub + longint'(cin);
    sum  = 32'(full & mask);
    cout = ((full >> w) & 1) != 0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    ss   = sa + sbv + longint'(cin);
    ovf  = (ss >= half) || (ss < -half);
    return {sum == 32'd0, ovf, cout, sum};
  endfunction

  function automatic logic [34:0] obs16();
    return {z16, of16, co16, 16'h0000, s16};
  endfunction

  function automatic logic [34:0] obs8();
    return {z8, of8, co8, 24'h000000, s8};
  endfunction

  // Scoreboard: record accepted beats, compare delivered beats in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov16 && or16) begin
        rcv16++;
        check("dut16_beat_expected", 35'(q16.size() != 0), 35'd1);
        if (q16.size() != 0) check("dut16_result", obs16(), q16.pop_front());
      end
      if (iv16 && ir16) q16.push_back(model(16, 32'(a16), 32'(b16), ci16, sb16));
      if (ov8 && or8) begin
        rcv8++;
        check("dut8_beat_expected", 35'(q8.size() != 0), 35'd1);
        if (q8.size() != 0) check("dut8_result", obs8(), q8.pop_front());
      end
      if (iv8 && ir8) q8.push_back(model(8, 32'(a8), 32'(b8), ci8, sb8));
    end
  end

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // Present one beat on the 16-bit instance and hold it until accepted.
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive16(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
    int t;
    a16 = a; b16 = b; ci16 = cin; sb16 = sub; iv16 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ir16 && t < 50);
    check("accept_timeout", 35'(ir16), 35'd1);
    @(posedge clk);
    #1;
    iv16 = 1'b0;
  endtask

  // Single isolated beat with exact latency and value checks.
  task automatic single16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [34:0] exp);
    @(posedge clk);
    #1;
    drive16(a, b, cin, sub);
    @(negedge clk);
    check({tag, "_no_bypass"}, 35'(ov16), 35'd0);
    @(negedge clk);
    check({tag, "_valid"}, 35'(ov16), 35'd1);
    check(tag, obs16(), exp);
  endtask

  logic [34:0] snap;
  logic [34:0] exp0;
  int base;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0; or16 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; ci8  = 1'b0; sb8  = 1'b0; or8  = 1'b1;
    #2;
    check("reset_out16", {35'(ov16), obs16()} , {35'd0, 35'd0});
    check("reset_out8", {35'(ov8), obs8()}, {35'd0, 35'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 35'(ir16), 35'd1);

    // Directed arithmetic cases
    single16("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 35'h0_0000_0100);
    single16("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 35'h5_0000_0000);
    single16("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 35'h2_0000_8000);
    single16("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 1'b1, 35'h3_0000_7FFF);
    single16("sub_0003_0005", 16'h0003, 16'h0005, 1'b1, 1'b1, 35'h0_0000_FFFE);
    single16("sub_borrow_in", 16'h0005, 16'h0003, 1'b0, 1'b1, 35'h1_0000_0001);

    // Backpressure: two beats fill the pipe while the output is stalled
    @(posedge clk);
    #1;
    or16 = 1'b0;
    exp0 = model(16, 32'h1234, 32'h1111, 1'b0, 1'b0);
    drive16(16'h1234, 16'h1111, 1'b0, 1'b0);
    drive16(16'hF000, 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", 35'(ir16), 35'd0);
    check("bp_out_valid", 35'(ov16), 35'd1);
    check("bp_first_result", obs16(), exp0);
    snap = obs16();
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_stable", obs16(), snap);
      check("bp_hold_ready", 35'(ir16), 35'd0);
    end
    @(posedge clk);
    #1;
    base = rcv16;
    or16 = 1'b1;
    drive16(16'h8000, 16'h8000, 1'b1, 1'b0);
    drive16(16'h0001, 16'h0001, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("bp_all_delivered", 35'(rcv16 - base), 35'd4);

    // Asynchronous reset mid-cycle with beats in flight
    @(posedge clk);
    #1;
    iv16 = 1'b1; a16 = 16'h00AA; b16 = 16'h0055;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_out", {35'(ov16), obs16()}, {35'd0, 35'd0});
    iv16 = 1'b0;
    q16.delete();
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_ready", 35'(ir16), 35'd1);
    repeat (4) @(negedge clk);
    check("post_reset_no_stale", 35'(ov16), 35'd0);

    // Random traffic on both instances with a reset pulse mid-stream
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 5000) begin
        rst = 1'b1;
        q16.delete();
        q8.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      iv16 = ($urandom_range(0, 3) != 0);
      or16 = ($urandom_range(0, 3) != 0);
      a16 = rnd16(); b16 = rnd16();
      ci16 = 1'($urandom); sb16 = 1'($urandom);
      iv8 = ($urandom_range(0, 3) != 0);
      or8 = ($urandom_range(0, 3) != 0);
      a8 = rnd8(); b8 = rnd8();
      ci8 = 1'($urandom); sb8 = 1'($urandom);
    end

    // Drain
    @(posedge clk);
    #1;
    iv16 = 1'b0; iv8 = 1'b0; or16 = 1'b1; or8 = 1'b1;
    repeat (6) @(negedge clk);
    check("drain_q16_empty", 35'(q16.size()), 35'd0);
    check("drain_q8_empty", 35'(q8.size()), 35'd0);
    check("traffic16_seen", 35'(rcv16 > 1000), 35'd1);
    check("traffic8_seen", 35'(rcv8 > 1000), 35'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, two-stage pipelined carry-select adder/subtractor. Successor to the team's fixed 8-bit combinational carry-select adder.
- Adds generic WIDTH and block size BLK, a subtract mode and an external carry-in.
- Adds status flags and a valid/ready stream interface with full backpressure.
- Sits between operand sources and result consumers in the datapath; throughput one operation per cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of BLK (elaboration error otherwise).
- BLK, 4, carry-select block width in bits; NBLK = WIDTH/BLK blocks, NBLK >= 1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept the operand beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- in_sub  input  1  1 = subtract mode (B inverted).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- out_sum  output  WIDTH  result.
- out_cout  output  1  raw carry-out of the MSB.
- out_ovf  output  1  two's-complement signed overflow.
- out_zero  output  1  out_sum == 0.

Behaviour:
- Reset (async, active-high): all valid bits and all data/flag registers clear to 0. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. in_ready=1 combinationally while the pipeline is empty.
- Arithmetic:
  - b_eff = in_sub ? ~in_b : in_b.
  - Full result = in_a + b_eff + in_cin, modulo 2^WIDTH.
  - SUB with in_cin=1 gives a-b. SUB with in_cin=0 gives a-b-1 (borrow chaining).
  - out_cout = carry out of bit WIDTH-1, no inversion in SUB.
  - out_ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
- Stage 1 (register S1 on advance):
  - Block 0 is computed with the real in_cin: sum plus carry.
  - Each block k=1..NBLK-1 is computed twice, with cin=0 and cin=1: sum0_k, sum1_k, c0_k, c1_k.
  - S1 also holds a[MSB] and b_eff[MSB], plus valid v1.
- Stage 2 (register S2 = output regs on advance):
  - Carry-select chain: c_k = c_{k-1} ? c1_k : c0_k; block sum chosen by the incoming carry.
  - out_cout = final carry. Flags are computed from the selected sum.
- Handshake:
  - adv2 = !out_valid || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1.
  - Input accepted when in_valid && in_ready.
  - v1 <= accepted when adv1; out_valid <= v1 when adv2.
- Latency: accepted beat appears on out_valid exactly 2 cycles later with no backpressure. Sustained throughput is 1 beat per cycle.
- Stall:
  - out_valid && !out_ready holds all S2 outputs stable.
  - S1 holds if v1.
  - The pipeline holds at most 2 beats; in_ready falls only when both stages are full and the output is stalled.
- Simultaneous accept and drain in the same cycle: both happen; no bubble, no loss, order preserved.
- Bypass from in_* to out_* is forbidden; the path is always 2 registers deep.
- Reset mid-operation: in-flight beats are discarded. No stale beat may appear after reset is released.
- NBLK=1: degenerates to a single block; the select chain is empty. Behaviour is otherwise identical.
- Data registers may be written when their stage is not valid. Output data content matters only while out_valid=1, except after reset (all zero).

Decomposition:
- Shared package csel_pkg:
  - function nblk(WIDTH,BLK);
  - a typedef struct for the per-block pair {sum0,sum1,c0,c1}, parametrised through the module's localparam;
  - a localparam for the flag-vector bit order {zero,ovf,cout}.
- Sub-module csel_block (parametrised by BLK): combinational ripple block producing the cin=0 and cin=1 sums and carries. Instantiated NBLK-1 times via generate.
- Block 0 is a plain ripple add with the real carry-in.

Test Plan (WIDTH=16, BLK=4 unless stated):
- Reset: assert rst asynchronously mid-cycle -> immediately out_valid=0, out_sum=0x0000, all flags 0. After release, in_ready=1.
- ADD 0x00FF+0x0001, cin=0, out_ready=1 -> 2 cycles after accept: sum=0x0100, cout=0, ovf=0, zero=0.
- ADD 0xFFFF+0x0001, cin=0 (carry through every select) -> sum=0x0000, cout=1, ovf=0, zero=1. Also 0x7FFF+0x0001 -> 0x8000, ovf=1, cout=0.
- SUB 0x8000-0x0001, cin=1 -> 0x7FFF, cout=1, ovf=1. Also SUB 0x0003-0x0005, cin=1 -> 0xFFFE, cout=0, ovf=0.
- Backpressure: stream 4 beats back-to-back with out_ready=0 for 3 cycles after the first result -> in_ready=0 with 2 beats held and output stable. On release, all 4 results appear in order, none lost or duplicated.
- Random/regression: 10k random ops with random in_valid/out_ready, at WIDTH=16/BLK=4 and WIDTH=8/BLK=8, checked against a behavioural model. Include a reset pulse mid-stream -> no pre-reset beat emerges afterwards.
